imem_responder: RTL and testbench



---
 rtl/imem_responder.sv | 129 ++++++++++++
 tb/tb_imem_responder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// Purpose : stand-in instruction memory answering fetch requests from a
//           word-addressed synchronous RAM with a side preload port.
// Latency : Latency cycles from request acceptance to a one-cycle rvalid.
// Backpr. : mem_ready_o drops on stall_i or when MaxOutstanding requests are
//           waiting for their response; responses themselves cannot stall.
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   mem_valid_i / mem_ready_o  request handshake, mem_addr_i is a byte address
//   mem_rdata_o / mem_rvalid_o in-order read data, one pulse per request
//   stall_i                    forces mem_ready_o low
//   load_we_i/addr/data        preload write port (word index)
module imem_responder #(
  parameter int Xlen           = 64,
  parameter int DepthLog2      = 10,
  parameter int Latency        = 1,
  parameter int MaxOutstanding = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 mem_valid_i,
  output logic                 mem_ready_o,
  input  logic [Xlen-1:0]      mem_addr_i,
  output logic [Xlen-1:0]      mem_rdata_o,
  output logic                 mem_rvalid_o,
  input  logic                 stall_i,
  input  logic                 load_we_i,
  input  logic [DepthLog2-1:0] load_addr_i,
  input  logic [Xlen-1:0]      load_data_i
);

  localparam int Depth     = 1 << DepthLog2;
  localparam int OffBits   = (Xlen == 64) ? 3 : 2;
  localparam int CntW      = $clog2(MaxOutstanding + 1);
  localparam int PipeDepth = (Latency > 1) ? Latency - 1 : 1;
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

  logic [Xlen-1:0]      ram_q [Depth];
  logic [CntW-1:0]      outstanding_q;
  logic [DepthLog2-1:0] req_idx;
  logic                 accept;
  logic                 launch_vld;
  logic [DepthLog2-1:0] launch_idx;
  logic                 unused_addr_bits;

  // Byte offset and bits above the RAM depth are dropped, so addresses wrap.
  assign req_idx          = mem_addr_i[OffBits +: DepthLog2];
  assign unused_addr_bits = ^mem_addr_i;

  assign mem_ready_o = !stall_i && (outstanding_q < MaxCnt);
  assign accept      = mem_valid_i && mem_ready_o;

  // "launch" is the edge that performs the RAM read and raises rvalid for a
  // request. With Latency=1 that is the accept edge itself; otherwise the
  // request first walks a Latency-1 deep {valid, index} shift pipeline.
  if (Latency == 1) begin : g_direct
    assign launch_vld = accept;
    assign launch_idx = req_idx;
  end else begin : g_pipe
    logic [PipeDepth-1:0] vld_q;
    logic [DepthLog2-1:0] idx_q [PipeDepth];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= accept;
        for (int i = 1; i < PipeDepth; i++) begin
          vld_q[i] <= vld_q[i-1];
        end
      end
    end

    // Index bits are qualified by vld_q, so they need no reset.
    always_ff @(posedge clk_i) begin
      idx_q[0] <= req_idx;
      for (int i = 1; i < PipeDepth; i++) begin
        idx_q[i] <= idx_q[i-1];
      end
    end

    assign launch_vld = vld_q[PipeDepth-1];
    assign launch_idx = idx_q[PipeDepth-1];
  end

  // Preload port; RAM contents survive reset.
  always_ff @(posedge clk_i) begin
    if (load_we_i) begin
      ram_q[load_addr_i] <= load_data_i;
    end
  end

  // Read sees the pre-write RAM contents when a load hits the same word on
  // the same edge (read-first).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_rvalid_o <= 1'b0;
      mem_rdata_o  <= '0;
    end else begin
      mem_rvalid_o <= launch_vld;
      if (launch_vld) begin
        mem_rdata_o <= ram_q[launch_idx];
      end
    end
  end

  // Counts requests accepted but not yet launched. A request is released on
  // its launch edge, so Latency=1 with one slot still sustains a request per
  // cycle, and MaxOutstanding < Latency throttles the requester.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_q <= '0;
    end else if (accept && !launch_vld) begin
      outstanding_q <= outstanding_q + CntW'(1);
    end else if (!accept && launch_vld) begin
      outstanding_q <= outstanding_q - CntW'(1);
    end
  end

`ifndef SYNTHESIS
  a_params_ok : assert property (@(posedge clk_i)
    (Latency >= 1) && (MaxOutstanding >= 1) && ((Xlen == 32) || (Xlen == 64)));
  a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
    outstanding_q <= MaxCnt);
  a_no_underflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(launch_vld && !accept && (outstanding_q == '0)));
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Purpose : randomized and directed bench for imem_responder, three
//           configurations driven in parallel against a queue-based model.
// Ports   : none (top-level bench).
module tb_imem_responder;

  localparam int NI = 3;

  logic        clk;
  logic        rst_n;
  logic        mem_valid;
  logic [63:0] mem_addr;
  logic        stall;
  logic        load_we;
  logic [9:0]  load_addr;
  logic [63:0] load_data;

  logic        rdy  [NI];
  logic        rvld [NI];
  logic [63:0] rdat [NI];

  int n_checks;
  int n_fail;

  // Reference model: the RAM image plus, per configuration, a FIFO of
  // accepted requests tagged with the edge number on which they must launch.
  int          lat_c  [NI];
  int          maxo_c [NI];
  logic [63:0] mram [1024];
  int unsigned q_edge [NI][8];
  int unsigned q_idx  [NI][8];
  int          q_head [NI];
  int          q_tail [NI];
  int unsigned ecnt;

  imem_responder #(.Xlen(64), .DepthLog2(10), .Latency(1), .MaxOutstanding(4)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .mem_valid_i(mem_valid), .mem_ready_o(rdy[0]),
    .mem_addr_i(mem_addr), .mem_rdata_o(rdat[0]), .mem_rvalid_o(rvld[0]),
    .stall_i(stall), .load_we_i(load_we), .load_addr_i(load_addr), .load_data_i(load_data));

  imem_responder #(.Xlen(64), .DepthLog2(10), .Latency(3), .MaxOutstanding(2)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .mem_valid_i(mem_valid), .mem_ready_o(rdy[1]),
    .mem_addr_i(mem_addr), .mem_rdata_o(rdat[1]), .mem_rvalid_o(rvld[1]),
    .stall_i(stall), .load_we_i(load_we), .load_addr_i(load_addr), .load_data_i(load_data));

  imem_responder #(.Xlen(64), .DepthLog2(10), .Latency(3), .MaxOutstanding(4)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .mem_valid_i(mem_valid), .mem_ready_o(rdy[2]),
    .mem_addr_i(mem_addr), .mem_rdata_o(rdat[2]), .mem_rvalid_o(rvld[2]),
    .stall_i(stall), .load_we_i(load_we), .load_addr_i(load_addr), .load_data_i(load_data));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < NI; k++) begin
      q_head[k] = 0;
      q_tail[k] = 0;
    end
  endtask

  // One clock cycle: inputs are already applied (called at posedge+1).
  task automatic step();
    bit          m_rdy [NI];
    bit          exp_v [NI];
    logic [63:0] exp_d [NI];
    int unsigned widx;
    widx = int'((mem_addr >> 3) % 64'd1024);
    #1;
    for (int k = 0; k < NI; k++) begin
      m_rdy[k] = !stall && ((q_tail[k] - q_head[k]) < maxo_c[k]);
      check_eq($sformatf("ready%0d@%0d", k, ecnt), {63'd0, rdy[k]}, {63'd0, m_rdy[k]});
    end
    @(posedge clk);
    for (int k = 0; k < NI; k++) begin
      exp_v[k] = 1'b0;
      exp_d[k] = '0;
      if (mem_valid && m_rdy[k]) begin
        q_edge[k][q_tail[k] % 8] = ecnt + lat_c[k] - 1;
        q_idx[k][q_tail[k] % 8]  = widx;
        q_tail[k]++;
      end
      if (q_head[k] < q_tail[k] && q_edge[k][q_head[k] % 8] == ecnt) begin
        exp_v[k] = 1'b1;
        exp_d[k] = mram[q_idx[k][q_head[k] % 8]];
        q_head[k]++;
      end
    end
    if (load_we) mram[load_addr] = load_data;
    ecnt++;
    #1;
    for (int k = 0; k < NI; k++) begin
      check_eq($sformatf("rvalid%0d@%0d", k, ecnt - 1), {63'd0, rvld[k]}, {63'd0, exp_v[k]});
      if (exp_v[k]) check_eq($sformatf("rdata%0d@%0d", k, ecnt - 1), rdat[k], exp_d[k]);
    end
  endtask

  task automatic load_word(input int idx, input logic [63:0] data);
    mem_valid = 1'b0;
    load_we   = 1'b1;
    load_addr = 10'(idx);
    load_data = data;
    step();
    load_we   = 1'b0;
  endtask

  task automatic req(input logic [63:0] addr);
    mem_valid = 1'b1;
    mem_addr  = addr;
    step();
  endtask

  task automatic idle(input int n);
    mem_valid = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    logic [63:0] a;
    n_checks = 0;
    n_fail   = 0;
    ecnt     = 0;
    lat_c  = '{1, 3, 3};
    maxo_c = '{4, 2, 4};
    model_clear();
    rst_n = 1'b0; mem_valid = 1'b0; mem_addr = '0; stall = 1'b0;
    load_we = 1'b0; load_addr = '0; load_data = '0;

    // Reset state
    #3;
    for (int k = 0; k < NI; k++) begin
      check_eq($sformatf("rst_rvalid%0d", k), {63'd0, rvld[k]}, 64'd0);
      check_eq($sformatf("rst_rdata%0d", k), rdat[k], 64'd0);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Preload words 0..31, then directed values
    for (int i = 0; i < 32; i++) load_word(i, {$urandom, $urandom});
    load_word(0, 64'h11); load_word(1, 64'h22); load_word(2, 64'h33); load_word(3, 64'h44);
    load_word(5, 64'h55);
    load_word(10'h200, 64'hDEAD_BEEF_0123_4567);

    // Back-to-back requests with valid held high
    req(64'h0); req(64'h8); req(64'h10); req(64'h18);
    idle(4);

    // Continuous valid: exercises the MaxOutstanding throttle of Latency=3
    for (int i = 0; i < 12; i++) req(64'(i % 8) << 3);
    idle(4);

    // Stall for five cycles with valid high, then release
    stall = 1'b1;
    for (int i = 0; i < 5; i++) req(64'h10);
    stall = 1'b0;
    req(64'h18);
    idle(4);

    // Address wrap: 0x1004 and 0x3004 land on word 0x200, 0x2004 on word 0
    req(64'h1004); req(64'h3004); req(64'h2004);
    idle(4);

    // Load hits word 5 on the Latency=1 read edge (old data expected there)
    mem_valid = 1'b1; mem_addr = 64'h28;
    load_we = 1'b1; load_addr = 10'd5; load_data = 64'hAA;
    step();
    load_we = 1'b0;
    idle(3);
    req(64'h28);
    idle(4);
    // Same collision aligned with the Latency=3 read edge
    load_word(5, 64'h55);
    req(64'h28);
    idle(1);
    load_word(5, 64'hAA);
    req(64'h28);
    idle(4);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      int idx;
      idx       = ($urandom_range(0, 9) == 0) ? 10'h200 : $urandom_range(0, 31);
      a         = {$urandom, $urandom};
      mem_addr  = (a & ~64'h1FFF) | (64'(idx) << 3) | 64'($urandom_range(0, 7));
      mem_valid = ($urandom_range(0, 9) < 7);
      stall     = ($urandom_range(0, 9) == 0);
      load_we   = ($urandom_range(0, 9) == 0);
      load_addr = 10'($urandom_range(0, 31));
      load_data = {$urandom, $urandom};
      step();
    end
    stall = 1'b0; load_we = 1'b0;
    idle(4);

    // Reset with requests in flight
    req(64'h8); req(64'h10); req(64'h18);
    mem_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      check_eq($sformatf("midrst_rvalid%0d", k), {63'd0, rvld[k]}, 64'd0);
      check_eq($sformatf("midrst_rdata%0d", k), rdat[k], 64'd0);
    end
    model_clear();
    @(posedge clk); @(posedge clk); #1;
    ecnt  = ecnt + 2;
    rst_n = 1'b1;
    idle(5);
    req(64'h18);
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
